// File: rtl/scan_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_pkg
// Purpose  : Shared types and constants for the scan sequencer slice.
//            Holds the FSM state encoding, the channel count and the select
//            width, plus a small helper for sizing the shared counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package scan_pkg;

   localparam int N_CHANNELS = 4;
   localparam int SEL_W      = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_DRIVE = 2'd2
   } scan_state_t;

   // Larger of two integers; used to size the shared dwell/blank counter.
   function automatic int max_int(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage : scan_pkg
`default_nettype wire

// File: rtl/scan_sequencer_next_channel_rr.sv
`default_nettype none
// ============================================================================
// Module   : next_channel_rr
// Purpose  : Combinational round-robin finder. Returns the first set mask
//            bit at or after a start point, wrapping modulo N_CHANNELS.
// Ports    : mask      i  per-channel enable bits
//            cur       i  current channel index
//            inclusive i  1: search starts at cur, 0: search starts at cur+1
//            next      o  selected channel (cur when nothing is set)
//            wrapped   o  the search passed the top index and came back
//            none      o  no mask bit is set
// Revision : 1.0 - initial release
// ============================================================================
module next_channel_rr
   import scan_pkg::*;
(
   input  logic [N_CHANNELS-1:0] mask,
   input  logic [SEL_W-1:0]      cur,
   input  logic                  inclusive,
   output logic [SEL_W-1:0]      next,
   output logic                  wrapped,
   output logic                  none
);

   always_comb begin
      next    = cur;
      none    = 1'b1;
      wrapped = 1'b0;
      // Walk offsets from farthest to nearest so the nearest hit wins.
      for (int k = N_CHANNELS - 1; k >= 0; k--) begin
         if (mask[SEL_W'(int'(cur) + k + int'(!inclusive))]) begin
            next = SEL_W'(int'(cur) + k + int'(!inclusive));
            none = 1'b0;
         end
      end
      // In exclusive mode landing back on cur is a full lap, so it counts
      // as a wrap; in inclusive mode only a strictly lower index does.
      if (!none) begin
         wrapped = inclusive ? (next < cur) : (next <= cur);
      end
   end

endmodule : next_channel_rr
`default_nettype wire

// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scan_sequencer
// Purpose  : Time-multiplexing sequencer for a 2-to-4 one-hot decoder.
//            Walks the channel index through the enabled mask bits, holding
//            each channel for DWELL_CYCLES with en high, separated by
//            BLANK_CYCLES with en low. frame_done pulses once per wrap.
// Ports    : clk        i  rising-edge clock
//            rst        i  synchronous active-low reset
//            ena        i  run request; low returns to idle
//            mask       i  per-channel scan enable
//            a          o  channel index to the decoder
//            en         o  decoder enable, high only while driving
//            frame_done o  single-cycle pulse on each channel wrap
// Revision : 1.0 - initial release
// ============================================================================
module scan_sequencer
   import scan_pkg::*;
#(
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic [N_CHANNELS-1:0] mask,
   output logic [SEL_W-1:0]      a,
   output logic                  en,
   output logic                  frame_done
);

   localparam int CNT_W = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES) + 1);
   localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);

   scan_state_t      state_q, state_d;
   logic [SEL_W-1:0] a_q,     a_d;
   logic             en_q,    en_d;
   logic             fd_q,    fd_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   logic [SEL_W-1:0] w_next;
   logic             w_wrapped;
   logic             w_none;
   logic             w_inclusive;
   logic             w_run;
   logic             w_cur_active;

   // Leaving idle may reuse the current index; every other selection moves on.
   assign w_inclusive  = (state_q == S_IDLE);
   assign w_run        = ena && (|mask);
   assign w_cur_active = mask[a_q];

   next_channel_rr u_finder (
      .mask      (mask),
      .cur       (a_q),
      .inclusive (w_inclusive),
      .next      (w_next),
      .wrapped   (w_wrapped),
      .none      (w_none)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      en_d    = 1'b0;
      fd_d    = 1'b0;
      cnt_d   = '0;

      if (!w_run) begin
         // Dropping ena or emptying the mask parks the sequencer with a held.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!w_none) begin
                  a_d     = w_next;
                  state_d = S_BLANK;
               end
            end

            S_BLANK: begin
               if (!w_cur_active) begin
                  // Channel vanished before it was driven: pick again and
                  // restart the gap. Not a wrap, so no frame_done here.
                  a_d = w_next;
               end else if (cnt_q == c_blank_last) begin
                  state_d = S_DRIVE;
                  en_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            S_DRIVE: begin
               if (!w_cur_active || (cnt_q == c_dwell_last)) begin
                  // en drops on the same edge that a changes.
                  a_d     = w_next;
                  state_d = S_BLANK;
                  fd_d    = w_wrapped;
               end else begin
                  en_d  = 1'b1;
                  cnt_d = cnt_q + 1'b1;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         en_q    <= 1'b0;
         fd_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         en_q    <= en_d;
         fd_q    <= fd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign a          = a_q;
   assign en         = en_q;
   assign frame_done = fd_q;

endmodule : scan_sequencer
`default_nettype wire

// File: tb/tb_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_sequencer
// Purpose  : Directed self-checking bench for scan_sequencer with
//            DWELL_CYCLES=4 and BLANK_CYCLES=2.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_sequencer;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [3:0] mask;
   logic [1:0] a;
   logic       en;
   logic       frame_done;

   int n_cmp;
   int n_err;

   scan_sequencer #(
      .DWELL_CYCLES (4),
      .BLANK_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .mask       (mask),
      .a          (a),
      .en         (en),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and sample just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [1:0] ea,
                      input logic een, input logic efd);
      n_cmp++;
      assert ({a, en, frame_done} === {ea, een, efd}) else begin
         n_err++;
         $error("FAIL %s: observed a=%0d en=%0b fd=%0b, expected a=%0d en=%0b fd=%0b",
                tag, a, en, frame_done, ea, een, efd);
      end
   endtask

   // One full channel slot: 2 blank cycles then 4 drive cycles.
   task automatic expect_channel(input string tag, input logic [1:0] ch,
                                 input logic efd);
      step(); chk({tag, "_blank0"}, ch, 1'b0, efd);
      step(); chk({tag, "_blank1"}, ch, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(); chk({tag, "_drive"}, ch, 1'b1, 1'b0);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b0;
      ena   = 1'b0;
      mask  = 4'b0000;

      // Reset state
      step(); chk("reset", 2'd0, 1'b0, 1'b0);
      step(); chk("reset_hold", 2'd0, 1'b0, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 7; i++) step();
      chk("idle_no_ena", 2'd0, 1'b0, 1'b0);

      // Full mask: 0,1,2,3 then wrap to 0 with frame_done
      mask = 4'b1111;
      ena  = 1'b1;
      expect_channel("m1111_ch0", 2'd0, 1'b0);
      expect_channel("m1111_ch1", 2'd1, 1'b0);
      expect_channel("m1111_ch2", 2'd2, 1'b0);
      expect_channel("m1111_ch3", 2'd3, 1'b0);
      expect_channel("m1111_wrap0", 2'd0, 1'b1);

      // Sparse mask 1010 switched in during the last drive cycle of ch0
      mask = 4'b1010;
      expect_channel("m1010_ch1", 2'd1, 1'b0);
      expect_channel("m1010_ch3", 2'd3, 1'b0);
      expect_channel("m1010_ch1w", 2'd1, 1'b1);
      expect_channel("m1010_ch3b", 2'd3, 1'b0);
      expect_channel("m1010_ch1w2", 2'd1, 1'b1);

      // Single channel: every switch is a wrap
      mask = 4'b0100;
      expect_channel("m0100_first", 2'd2, 1'b0);
      expect_channel("m0100_w1", 2'd2, 1'b1);
      expect_channel("m0100_w2", 2'd2, 1'b1);

      // Drop ena on the 2nd drive cycle of channel 2
      step(); chk("ena_blank0", 2'd2, 1'b0, 1'b1);
      step(); chk("ena_blank1", 2'd2, 1'b0, 1'b0);
      step(); chk("ena_drive0", 2'd2, 1'b1, 1'b0);
      step(); chk("ena_drive1", 2'd2, 1'b1, 1'b0);
      ena = 1'b0;
      step(); chk("ena_low_idle", 2'd2, 1'b0, 1'b0);
      step(); chk("ena_low_hold", 2'd2, 1'b0, 1'b0);

      // Re-raise: resume on channel 2, no frame_done leaving idle
      ena  = 1'b1;
      mask = 4'b1111;
      expect_channel("reena_ch2", 2'd2, 1'b0);
      expect_channel("reena_ch3", 2'd3, 1'b0);
      expect_channel("reena_ch0", 2'd0, 1'b1);

      // Clear current bit while driving channel 1
      step(); chk("clr_ch1_blank0", 2'd1, 1'b0, 1'b0);
      step(); chk("clr_ch1_blank1", 2'd1, 1'b0, 1'b0);
      step(); chk("clr_ch1_drive", 2'd1, 1'b1, 1'b0);
      mask = 4'b1101;
      step(); chk("clr_early_end", 2'd2, 1'b0, 1'b0);
      mask = 4'b0000;
      step(); chk("mask0_idle", 2'd2, 1'b0, 1'b0);
      step(); chk("mask0_hold", 2'd2, 1'b0, 1'b0);

      // Reset mid-drive
      mask = 4'b1111;
      step(); chk("pre_rst_blank0", 2'd2, 1'b0, 1'b0);
      step(); chk("pre_rst_blank1", 2'd2, 1'b0, 1'b0);
      step(); chk("pre_rst_drive", 2'd2, 1'b1, 1'b0);
      rst = 1'b0;
      step(); chk("rst_mid_drive", 2'd0, 1'b0, 1'b0);
      step(); chk("rst_hold", 2'd0, 1'b0, 1'b0);
      rst = 1'b1;
      expect_channel("post_rst_ch0", 2'd0, 1'b0);

      // Current bit clears during blank: reselect and restart the gap
      step(); chk("blank_clr_ch1", 2'd1, 1'b0, 1'b0);
      mask = 4'b1101;
      step(); chk("reselect_blank0", 2'd2, 1'b0, 1'b0);
      step(); chk("reselect_blank1", 2'd2, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(); chk("reselect_drive", 2'd2, 1'b1, 1'b0);
      end
      step(); chk("reselect_next", 2'd3, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_scan_sequencer
`default_nettype wire

// File: doc/scan_sequencer.md
# scan_sequencer

Time-multiplexing sequencer that drives the select/enable pair of the 2-to-4 one-hot decoder stage in the display/LED scan path. It walks a 2-bit channel index through the enabled channels of a 4-bit mask, holding each channel active for a programmable dwell time. A blanking gap with `en` low separates consecutive channels so the decoder outputs never overlap. A one-cycle pulse marks each completed frame.

## Interface
- `DWELL_CYCLES`, default 1000: cycles `en` stays high per channel; legal range ≥ 1.
- `BLANK_CYCLES`, default 2: cycles `en` stays low between channels; legal range ≥ 1.
- `clk`  input  1  sole clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `ena`  input  1  run request; low forces the idle state.
- `mask`  input  4  per-channel enable; bit i set means channel i is scanned.
- `a`  output  2  channel index; feeds the decoder's `a`.
- `en`  output  1  decoder enable; high only while in DRIVE.
- `frame_done`  output  1  single-cycle pulse at each channel wrap.

## Operation
- All outputs are registered.
- Reset values: `a`=0, `en`=0, `frame_done`=0, state IDLE, counter 0.
- States and transitions:
  - IDLE: `en`=0. If `ena`=1 and `mask`≠0, load `a` with the first set mask bit searching from the current `a` inclusive, upward with wrap. Then go to BLANK. Otherwise stay in IDLE.
  - BLANK: `en`=0, `a` stable. After `BLANK_CYCLES` cycles, go to DRIVE.
  - DRIVE: `en`=1, `a` stable. After `DWELL_CYCLES` cycles, compute the next channel and go to BLANK with the new `a`.
- Next-channel search: the first set mask bit starting at `a`+1 mod 4, wrapping. If only the current bit is set, the result is the same channel; it is still separated by a BLANK gap.
- Wrap: `frame_done`=1 in the first BLANK cycle of a channel whose index ≤ the previous channel's index. This includes the single-channel case, where every switch is a wrap. It is never asserted when leaving IDLE.
- `ena` falls in any state: next cycle goes to IDLE with `en`=0 and `a` held; the counter clears.
- `mask` becomes 0 in any state: next cycle goes to IDLE.
- Current channel's mask bit clears during DRIVE: the dwell ends early. Next cycle computes the next channel and goes to BLANK.
- Current channel's mask bit clears during BLANK: re-select the next channel next cycle and restart the blank count. No `frame_done` is generated by this re-select.
- Other mask bits changing take effect at the next channel selection only.
- `rst` low overrides everything, including mid-DRIVE. Outputs return to reset values on that edge.

## Timing
- `ena`/`mask` sampled at edge N (from IDLE): BLANK from N+1, `en` low through N+`BLANK_CYCLES`. `en` is high from N+`BLANK_CYCLES`+1 for exactly `DWELL_CYCLES` cycles.
- Channel period: `BLANK_CYCLES`+`DWELL_CYCLES` cycles.
- Frame period: k·(`BLANK_CYCLES`+`DWELL_CYCLES`) cycles, for k set mask bits.
- `a` changes only in the same cycle `en` goes low, or while `en` is already low. `en` is never high across an `a` change.
- Counter width: $clog2(max(`DWELL_CYCLES`,`BLANK_CYCLES`)+1). Counting is from 0 upward; the terminal compare is count == limit−1.

## Structure
- Shared package `scan_pkg`:
  - state enum `scan_state_t` {S_IDLE, S_BLANK, S_DRIVE};
  - `N_CHANNELS`=4;
  - `SEL_W`=2.
- One sub-module, `next_channel_rr`: combinational round-robin finder.
  - Inputs: `mask`, `cur`, `inclusive`.
  - Outputs: `next`, `wrapped`, `none`.
  - Used for both the IDLE→BLANK search and the DRIVE→BLANK search.
- Sequencer: FSM plus a single shared dwell/blank counter.

## Test plan
- Bench parameters DWELL=4, BLANK=2, `mask`=4'b1111, `ena` raised at cycle 10:
  - `a` = 0,1,2,3,0 with 2 low and 4 high `en` cycles each;
  - `frame_done` pulses once at the 0 re-entry, 24 cycles after the first BLANK.
- `mask`=4'b1010 -> `a` alternates 1,3,1; `frame_done` pulses on each entry to channel 1 after 3.
- `mask`=4'b0100 -> `a` stays 2; `en` pattern is 2 low / 4 high; `frame_done` pulses every 6 cycles.
- `ena` dropped on the 2nd DRIVE cycle of channel 2 -> next cycle `en`=0, `a`=2, IDLE.
  - Re-raise `ena` -> BLANK on channel 2 with no `frame_done`.
- Clear `mask[1]` while driving channel 1 (`mask` 4'b1111→4'b1101) -> `en` low next cycle, `a`=2. Then set `mask`=0 -> IDLE, `en` stays 0.
- Assert `rst`=0 mid-DRIVE -> `a`=0, `en`=0, `frame_done`=0 on that edge. Release `rst` -> sequence restarts from channel 0.
